pwm_update_scheduler: RTL

//  Sequences PWM parameter updates through the free-running pwm_preconditioner. Accepts a
//  4-phase update request, freezes the CYCLE/DUTY/PHASE source until the preconditioner has

---
 rtl/pwm_sched_pkg.sv | 21 ++
 rtl/pwm_update_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and default timeout/width constants for the PWM update scheduler and pwm top.
package pwm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CAPTURE,
    WAIT_RESULT,
    WAIT_BOUNDARY,
    COMMIT,
    ACK_HOLD
  } sched_state_t;

  localparam int DONE_TIMEOUT_DEF  = 1024;
  localparam int BOUND_TIMEOUT_DEF = 16384;
  localparam int CNT_WIDTH_DEF     = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_update_scheduler.sv
// Sequences one CYCLE/DUTY/PHASE update through the preconditioner, then strobes COMMIT to the shadow regs.
// Latency: REQ -> COMMIT = 1 + capture wait + one preconditioner pass + 1 (plus period wait when SYNC_MODE=1).
// Backpressure: REQ/ACK four-phase handshake; REQ sampled only in IDLE, ACK held until REQ drops.
module pwm_update_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DONE_TIMEOUT  = DONE_TIMEOUT_DEF,
  parameter int BOUND_TIMEOUT = BOUND_TIMEOUT_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ,
  output logic                 ACK,
  input  logic                 SYNC_MODE,
  input  logic                 PRE_DONE,
  input  logic                 PERIOD_START,
  output logic                 SRC_LOCK,
  output logic                 COMMIT,
  output logic                 BUSY,
  output logic                 ERR,
  input  logic                 ERR_CLR,
  output logic [CNT_WIDTH-1:0] UPDATE_CNT
);

  localparam int TW = $clog2(max2(DONE_TIMEOUT, BOUND_TIMEOUT));
  localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] BOUND_LAST = TW'(BOUND_TIMEOUT - 1);

  sched_state_t  state;
  sched_state_t  next_state;
  logic [TW-1:0] timer;
  logic          timeout_hit;

  // The COMMIT state literal is scoped explicitly because the output port shares its name.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (REQ) next_state = WAIT_CAPTURE;
      end
      WAIT_CAPTURE: begin
        if (PRE_DONE) begin
          next_state = WAIT_RESULT;
        end else if (timer == DONE_LAST) begin
          next_state  = ACK_HOLD;
          timeout_hit = 1'b1;
        end
      end
      WAIT_RESULT: begin
        if (PRE_DONE) begin
          next_state = SYNC_MODE ? WAIT_BOUNDARY : pwm_sched_pkg::COMMIT;
        end else if (timer == DONE_LAST) begin
          next_state  = ACK_HOLD;
          timeout_hit = 1'b1;
        end
      end
      WAIT_BOUNDARY: begin
        if (PERIOD_START) begin
          next_state = pwm_sched_pkg::COMMIT;
        end else if (timer == BOUND_LAST) begin
          next_state  = ACK_HOLD;
          timeout_hit = 1'b1;
        end
      end
      pwm_sched_pkg::COMMIT: begin
        next_state = ACK_HOLD;
      end
      ACK_HOLD: begin
        if (!REQ) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      timer      <= '0;
      ACK        <= 1'b0;
      SRC_LOCK   <= 1'b0;
      COMMIT     <= 1'b0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
      UPDATE_CNT <= '0;
    end else begin
      state    <= next_state;
      ACK      <= (next_state == ACK_HOLD);
      SRC_LOCK <= (next_state == WAIT_CAPTURE);
      COMMIT   <= (next_state == pwm_sched_pkg::COMMIT);
      BUSY     <= (next_state != IDLE);

      if (next_state != state) begin
        timer <= '0;
      end else if (state inside {WAIT_CAPTURE, WAIT_RESULT, WAIT_BOUNDARY}) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end

      if (next_state == pwm_sched_pkg::COMMIT) UPDATE_CNT <= UPDATE_CNT + CNT_WIDTH'(1);

      if (timeout_hit) begin
        ERR <= 1'b1;
      end else if (ERR_CLR) begin
        ERR <= 1'b0;
      end
    end
  end

endmodule
